// File: rtl/stream_demux_if.sv
// Stream demux handshake bundle.
// One producer-side stream, N consumer-side valid/ready lanes.
interface stream_demux_if #(
  parameter int WIDTH = 64,
  parameter int N     = 5
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inData;
  logic [2:0]       inSel;
  logic [N-1:0]     outValid;
  logic [N-1:0]     outReady;
  logic [WIDTH-1:0] outData;

  modport slave (
    input  inValid, inData, inSel, outReady,
    output inReady, outValid, outData
  );

  modport master (
    output inValid, inData, inSel, outReady,
    input  inReady, outValid, outData
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux with 2-entry skid buffer.
// Upstream ready comes from state only; order is preserved.
module stream_demux #(
  parameter int WIDTH = 64,
  parameter int N     = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  stream_demux_if.slave s,
  output logic        selErr,
  input  logic        clrErr,
  output logic [15:0] xferCount
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [2:0]       main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [2:0]       skid_sel_q, skid_sel_d;
  logic             sel_err_q, sel_err_d;
  logic [15:0]      xfer_q, xfer_d;

  logic             in_ready;
  logic             in_fire;
  logic             sel_ok;
  logic             in_good;
  logic             main_v;
  logic             out_fire;
  logic [N-1:0]     out_valid;

  // Handshake decode and one-hot presentation of the head beat
  always_comb begin
    in_ready = (state_q != TWO);
    main_v   = (state_q != EMPTY);
    sel_ok   = ({1'b0, s.inSel} < 4'(N));
    in_fire  = s.inValid & in_ready;
    in_good  = in_fire & sel_ok;
    out_valid = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = main_v && (main_sel_q == 3'(i));
    end
    out_fire = |(out_valid & s.outReady);
  end

  // Buffer next-state, error flag and delivery counter
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    sel_err_d   = sel_err_q;
    xfer_d      = xfer_q;

    unique case (state_q)
      EMPTY: begin
        if (in_good) begin
          state_d     = ONE;
          main_data_d = s.inData;
          main_sel_d  = s.inSel;
        end
      end
      ONE: begin
        if (in_good && !out_fire) begin
          state_d     = TWO;
          skid_data_d = s.inData;
          skid_sel_d  = s.inSel;
        end else if (in_good && out_fire) begin
          main_data_d = s.inData;
          main_sel_d  = s.inSel;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (in_fire && !sel_ok) begin
      sel_err_d = 1'b1;
    end else if (clrErr) begin
      sel_err_d = 1'b0;
    end

    if (out_fire) begin
      xfer_d = xfer_q + 16'd1;
    end
  end

  // State registers; reset also zeroes payload so outData is never X
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      sel_err_q   <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      sel_err_q   <= sel_err_d;
      xfer_q      <= xfer_d;
    end
  end

  assign s.inReady  = in_ready;
  assign s.outValid = out_valid;
  assign s.outData  = main_data_q;
  assign selErr     = sel_err_q;
  assign xferCount  = xfer_q;

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux.
// Reference model is a FIFO queue of accepted beats.
module tb_stream_demux;
  localparam int W = 64;
  localparam int N = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clrErr = 1'b0;
  logic        selErr;
  logic [15:0] xferCount;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(W), .N(N)) ifc();

  stream_demux #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s         (ifc),
    .selErr    (selErr),
    .clrErr    (clrErr),
    .xferCount (xferCount)
  );

  typedef struct {
    logic [W-1:0] d;
    int           sel;
  } beat_t;

  beat_t       q[$];
  int          vecs = 0;
  int          errs = 0;
  logic [15:0] cnt_m;
  logic        err_m;

  function automatic logic [N-1:0] exp_ov();
    logic [N-1:0] v;
    v = '0;
    if (q.size() > 0) v[q[0].sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] exp_od();
    if (q.size() > 0) return q[0].d;
    return ifc.outData;
  endfunction

  task automatic drive(input bit v, input logic [2:0] sel,
                       input logic [W-1:0] d);
    ifc.inValid = v;
    ifc.inSel   = sel;
    ifc.inData  = d;
  endtask

  // Advance one clock, updating the queue model from the
  // inputs present just before the edge.
  task automatic step(output bit acc);
    bit           fi, fo;
    logic [2:0]   s;
    logic [W-1:0] d;
    beat_t        b;
    fi  = ifc.inValid && (q.size() < 2);
    fo  = (q.size() > 0) && ifc.outReady[q[0].sel];
    s   = ifc.inSel;
    d   = ifc.inData;
    acc = fi;
    @(posedge clk);
    if (fo) begin
      void'(q.pop_front());
      cnt_m = cnt_m + 16'd1;
    end
    if (fi && int'(s) < N) begin
      b.d = d;
      b.sel = int'(s);
      q.push_back(b);
    end
    if (fi && int'(s) >= N) err_m = 1'b1;
    else if (clrErr) err_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 3'd0, '0);
    ifc.outReady = '0;
    clrErr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    cnt_m = '0;
    err_m = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 3'd0, '0);
    ifc.outReady = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (ifc.outValid !== '0) begin
      errs++; $display("FAIL rst_outValid act=%h exp=0", ifc.outValid);
    end
    vecs++;
    if (ifc.inReady !== 1'b1) begin
      errs++; $display("FAIL rst_inReady act=%b exp=1", ifc.inReady);
    end
    vecs++;
    if (selErr !== 1'b0) begin
      errs++; $display("FAIL rst_selErr act=%b exp=0", selErr);
    end
    vecs++;
    if (xferCount !== 16'd0) begin
      errs++; $display("FAIL rst_xfer act=%h exp=0", xferCount);
    end
    vecs++;
    if (ifc.outData !== '0) begin
      errs++; $display("FAIL rst_outData act=%h exp=0", ifc.outData);
    end
    reset_n = 1'b1;
    q.delete();
    cnt_m = '0;
    err_m = 1'b0;
  endtask

  task automatic test_basic();
    bit acc;
    ifc.outReady = '1;
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, 3'(i % 5), W'(8'h10 + i));
      vecs++;
      if (ifc.outValid !== exp_ov()) begin
        errs++;
        $display("FAIL basic_ov act=%h exp=%h", ifc.outValid, exp_ov());
      end
      vecs++;
      if (ifc.outData !== exp_od()) begin
        errs++;
        $display("FAIL basic_od act=%h exp=%h", ifc.outData, exp_od());
      end
      vecs++;
      if (ifc.inReady !== 1'b1) begin
        errs++; $display("FAIL basic_rdy act=%b exp=1", ifc.inReady);
      end
      step(acc);
    end
    vecs++;
    if (xferCount !== 16'd8 || cnt_m !== 16'd8) begin
      errs++; $display("FAIL basic_xfer act=%0d exp=8", xferCount);
    end
  endtask

  task automatic test_stall();
    bit acc;
    int sent = 0;
    int cyc = 0;
    do_reset();
    while ((sent < 3 || q.size() > 0) && cyc < 30) begin
      if (cyc == 8) ifc.outReady = 5'b00100;
      drive(sent < 3, 3'd2, W'(64'hA0 + sent));
      vecs++;
      if (ifc.outValid !== exp_ov()) begin
        errs++;
        $display("FAIL stall_ov act=%h exp=%h", ifc.outValid, exp_ov());
      end
      vecs++;
      if (ifc.outValid !== '0 && ifc.outData !== exp_od()) begin
        errs++;
        $display("FAIL stall_od act=%h exp=%h", ifc.outData, exp_od());
      end
      vecs++;
      if (ifc.inReady !== (q.size() < 2)) begin
        errs++;
        $display("FAIL stall_rdy act=%b exp=%b", ifc.inReady, q.size() < 2);
      end
      step(acc);
      if (acc) sent++;
      cyc++;
    end
    vecs++;
    if (sent != 3 || q.size() != 0) begin
      errs++; $display("FAIL stall_timeout act=%0d exp=3", sent);
    end
    vecs++;
    if (xferCount !== 16'd3 || ifc.inReady !== 1'b1) begin
      errs++;
      $display("FAIL stall_end act=%0d/%b exp=3/1", xferCount, ifc.inReady);
    end
  endtask

  task automatic test_hol();
    bit acc;
    do_reset();
    ifc.outReady = 5'b00001;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) ifc.outReady = 5'b00011;
      if (c == 0) drive(1, 3'd1, W'(64'hB1));
      else if (c == 1) drive(1, 3'd0, W'(64'hB0));
      else drive(0, 3'd0, '0);
      vecs++;
      if (ifc.outValid !== exp_ov()) begin
        errs++;
        $display("FAIL hol_ov c=%0d act=%h exp=%h", c, ifc.outValid, exp_ov());
      end
      vecs++;
      if (ifc.outValid !== '0 && ifc.outData !== exp_od()) begin
        errs++;
        $display("FAIL hol_od act=%h exp=%h", ifc.outData, exp_od());
      end
      step(acc);
    end
    vecs++;
    if (xferCount !== 16'd2) begin
      errs++; $display("FAIL hol_xfer act=%0d exp=2", xferCount);
    end
  endtask

  task automatic test_selerr();
    bit acc;
    do_reset();
    ifc.outReady = '1;
    drive(1, 3'd6, W'(64'hE6));
    step(acc);
    drive(0, 3'd0, '0);
    vecs++;
    if (selErr !== 1'b1 || err_m !== 1'b1) begin
      errs++; $display("FAIL err_set act=%b exp=1", selErr);
    end
    vecs++;
    if (ifc.outValid !== '0) begin
      errs++; $display("FAIL err_ov act=%h exp=0", ifc.outValid);
    end
    step(acc);
    vecs++;
    if (xferCount !== 16'd0) begin
      errs++; $display("FAIL err_xfer act=%0d exp=0", xferCount);
    end
    drive(1, 3'd7, W'(64'hE7));
    clrErr = 1'b1;
    step(acc);
    drive(0, 3'd0, '0);
    vecs++;
    if (selErr !== 1'b1) begin
      errs++; $display("FAIL err_setwins act=%b exp=1", selErr);
    end
    step(acc);
    clrErr = 1'b0;
    vecs++;
    if (selErr !== 1'b0) begin
      errs++; $display("FAIL err_clr act=%b exp=0", selErr);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    do_reset();
    ifc.outReady = '0;
    drive(1, 3'd4, W'(64'hC0));
    step(acc);
    drive(1, 3'd3, W'(64'hC1));
    step(acc);
    drive(0, 3'd0, '0);
    vecs++;
    if (ifc.inReady !== 1'b0) begin
      errs++; $display("FAIL mid_two act=%b exp=0", ifc.inReady);
    end
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if (ifc.outValid !== '0) begin
      errs++; $display("FAIL mid_async act=%h exp=0", ifc.outValid);
    end
    q.delete();
    cnt_m = '0;
    err_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ifc.outReady = '1;
    for (int c = 0; c < 4; c++) begin
      vecs++;
      if (ifc.outValid !== '0 || ifc.inReady !== 1'b1) begin
        errs++;
        $display("FAIL mid_stale act=%h/%b exp=0/1", ifc.outValid,
                 ifc.inReady);
      end
      step(acc);
    end
    vecs++;
    if (xferCount !== 16'd0) begin
      errs++; $display("FAIL mid_xfer act=%0d exp=0", xferCount);
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            {$urandom, $urandom});
      ifc.outReady = N'($urandom);
      clrErr = ($urandom_range(0, 15) == 0);
      vecs++;
      if (ifc.outValid !== exp_ov()) begin
        errs++;
        $display("FAIL rnd_ov c=%0d act=%h exp=%h", c, ifc.outValid,
                 exp_ov());
      end
      vecs++;
      if (ifc.outData !== exp_od()) begin
        errs++;
        $display("FAIL rnd_od c=%0d act=%h exp=%h", c, ifc.outData,
                 exp_od());
      end
      vecs++;
      if (ifc.inReady !== (q.size() < 2)) begin
        errs++;
        $display("FAIL rnd_rdy c=%0d act=%b exp=%b", c, ifc.inReady,
                 q.size() < 2);
      end
      vecs++;
      if (selErr !== err_m || xferCount !== cnt_m) begin
        errs++;
        $display("FAIL rnd_state c=%0d act=%b/%0d exp=%b/%0d", c, selErr,
                 xferCount, err_m, cnt_m);
      end
      step(acc);
    end
    clrErr = 1'b0;
  endtask

  task automatic test_wrap();
    bit acc;
    int sent = 0;
    int cyc = 0;
    int bad = 0;
    do_reset();
    ifc.outReady = '1;
    while ((sent < 65537 || q.size() > 0) && cyc < 70000) begin
      drive(sent < 65537, 3'd3, {32'(sent), $urandom});
      if (ifc.outValid !== exp_ov() ||
          (q.size() > 0 && ifc.outData !== exp_od())) begin
        bad++;
        if (bad < 5)
          $display("FAIL wrap_data c=%0d act=%h exp=%h", cyc, ifc.outData,
                   exp_od());
      end
      step(acc);
      if (acc) sent++;
      cyc++;
    end
    vecs++;
    if (bad != 0) errs++;
    vecs++;
    if (sent != 65537 || q.size() != 0) begin
      errs++; $display("FAIL wrap_timeout act=%0d exp=65537", sent);
    end
    vecs++;
    if (xferCount !== 16'h0001 || cnt_m !== 16'h0001) begin
      errs++; $display("FAIL wrap_count act=%h exp=0001", xferCount);
    end
    vecs++;
    if (cyc > 65540) begin
      errs++; $display("FAIL wrap_rate act=%0d exp<=65540", cyc);
    end
  endtask

  initial begin
    drive(0, 3'd0, '0);
    ifc.outReady = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_hol();
    test_selerr();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer with a valid/ready handshake, so the select-driven datapath can steer one producer to one of N consumers. It accepts one beat per cycle (data plus binary destination select) into a 2-entry skid buffer. It presents the buffered beat to the selected output only. Upstream ready is taken from registers only, which breaks the combinational ready path between consumers and producer.

## Interface
Parameters:
- WIDTH, 64, data width of every beat.
- N, 5, number of output ports (legal range 2..8).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset. Assertion clears state immediately. Deassertion is synchronous to clk.
- inValid  input  1  producer has a beat.
- inReady  output  1  block can accept a beat this cycle.
- inData  input  WIDTH  beat payload.
- inSel  input  3  destination index, binary.
- outValid  output  N  one-hot-or-zero; bit i means port i has a beat.
- outReady  input  N  per-port consumer ready.
- outData  output  WIDTH  payload, shared by all ports; meaningful only where outValid is set.
- selErr  output  1  sticky flag: a beat with inSel >= N was accepted and discarded.
- clrErr  input  1  synchronous clear of selErr.
- xferCount  output  16  count of delivered beats; wraps 0xFFFF -> 0x0000.

## Operation
- Storage is a main register and a skid register, each holding {data, sel, valid}. Buffer states:
  - EMPTY: neither register valid.
  - ONE: main valid only.
  - TWO: main and skid valid.
- inReady = (state != TWO). It is a pure function of registered state, with no combinational dependence on outReady or inValid.
- inFire = inValid & inReady.
- outValid[i] = mainValid & (mainSel == i). outData = mainData.
- outFire = mainValid & outReady[mainSel]. outReady bits of unselected ports are ignored.
- Only beats with inSel < N are stored. A beat with inSel >= N is consumed on inFire, never stored, never presented, and sets selErr the next cycle.
- Let inGood = inFire & (inSel < N). Transitions:
  - EMPTY + inGood -> ONE; main loads the input.
  - ONE + inGood & !outFire -> TWO; skid loads the input.
  - ONE + inGood & outFire -> ONE; main reloads with the input.
  - ONE + !inGood & outFire -> EMPTY.
  - TWO + outFire -> ONE; main loads from skid.
  - TWO + !outFire -> TWO. No input is accepted in TWO.
  - Otherwise the state holds.
- Order is preserved. Beats leave in acceptance order regardless of destination, so a stalled port blocks all ports (head-of-line blocking is intended).
- Stored data is stable while valid and unaccepted. outValid never deasserts without outFire, except on reset.
- xferCount increments by 1 on each outFire. Discarded beats are not counted.
- selErr:
  - Set by an accepted bad-select beat.
  - Cleared by clrErr.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: outValid = 0, inReady = 1, selErr = 0, xferCount = 0, outData = 0, buffer EMPTY.
- Latency: a beat accepted at edge k is presented on outValid in the cycle after edge k, i.e. 1 cycle.
- Throughput is 1 beat/cycle sustained when the destination outReady is held high.
- After a stall, inReady reasserts the cycle after the first outFire out of TWO.
- Reset asserted mid-transfer discards both buffered beats immediately, with no output glitch beyond outValid going low asynchronously.
- No X on outputs after reset, including outData.

## Test plan
- Reset, then 8 beats with inData = 0x10..0x17 and inSel cycling 0..4, all outReady = 1 -> each beat appears on the matching outValid bit exactly 1 cycle after acceptance; inReady stays 1; xferCount = 8.
- outReady = 0 on all ports, send 3 beats to port 2 -> first two accepted; inReady drops after the 2nd; third stalls with inValid held. Raise outReady[2] -> 3 deliveries in order and inReady back to 1; xferCount = 3.
- Beat to port 1 stalls with outReady[1] = 0 while outReady[0] = 1, followed by a beat to port 0 -> port 0 beat waits until port 1 fires (head-of-line), then follows on the next cycle.
- Send inSel = 6 with N = 5 -> beat accepted, nothing on outValid, selErr = 1 next cycle, xferCount unchanged. clrErr together with another inSel = 7 beat -> selErr stays 1. clrErr alone -> selErr = 0.
- Fill to TWO, then assert reset_n = 0 asynchronously mid-cycle -> outValid = 0 immediately. After release: inReady = 1, xferCount = 0, and no stale beat emerges.
- Run 65537 deliveries to port 3 at full rate -> xferCount wraps and reads 0x0001; no dropped or duplicated data, checked by a scoreboard.
